clock_mode_ctrl: RTL and testbench
==================================

Name: clock_mode_ctrl

Overview:
Key-driven mode sequencer for the alarm clock. It sits between the 8-bit key bank and the timekeeper/LCD path. It synchronises and debounces keys, runs the NORMAL / SET_TIME / SET_ALARM / RINGING state machine, and edits a shadow hour/minute with per-field wrap-around. It also loads edited time into the timekeeper, holds the alarm registers, and raises the buzzer on alarm match.

Parameters:
DEB_CYCLES, 50000, cycles a key level must be stable before it is accepted (CLK=50 MHz gives 1 ms)
RING_SEC, 60, seconds the alarm rings before it stops itself

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous reset, active-high
KEY  in  8  raw key levels, active-high; [0]=MODE [1]=NEXT [2]=UP [3]=DOWN [4]=ALM_EN toggle [5]=STOP; [7:6] ignored
SEC_TICK  in  1  one-cycle pulse per second from the timekeeper
CUR_HOUR  in  5  timekeeper hour, 0-23
CUR_MIN  in  6  timekeeper minute, 0-59
CUR_SEC  in  6  timekeeper second, 0-59
SET_LOAD  out  1  one-cycle pulse; timekeeper loads SET_HOUR/SET_MIN and seconds=0
SET_HOUR  out  5  shadow hour
SET_MIN  out  6  shadow minute
MODE  out  2  0=NORMAL 1=SET_TIME 2=SET_ALARM 3=RINGING
FLAG  out  3  one-hot cursor: [0]=hour field, [1]=minute field, [2]=alarm enabled
MERIDIAN  out  1  1 when the displayed hour is >= 12 (PM)
ALM_HOUR  out  5  stored alarm hour
ALM_MIN  out  6  stored alarm minute
BUZZ  out  1  alarm buzzer drive

Behaviour:
- Reset (sync, active-high) values: MODE=0, FLAG=3'b001, SET_LOAD=0, SET_HOUR=0, SET_MIN=0, ALM_HOUR=6, ALM_MIN=0, alarm disabled, BUZZ=0, MERIDIAN=0. Reset also clears debounce counters and the ring counter.
- Key path: each of KEY[5:0] passes through a 2-FF synchroniser and then a debounce counter. The accepted level changes only after DEB_CYCLES consecutive equal samples.
- A key "press" is a rising edge of the accepted level: a one-cycle internal pulse. Release is ignored. Key latency from stable raw level to action is DEB_CYCLES+3 cycles.
- Simultaneous presses in one cycle are resolved with priority STOP > MODE > NEXT > UP > DOWN > ALM_EN. Only the highest-priority press acts; the others are dropped.
- NORMAL:
  - MODE press: copy CUR_HOUR/CUR_MIN into the shadow, set cursor to hour, go to SET_TIME.
  - ALM_EN press: toggle FLAG[2].
- SET_TIME:
  - NEXT press: toggle cursor between hour and minute.
  - UP/DOWN press: +/-1 on the selected shadow field. Hour wraps 23->0 and 0->23; minute wraps 59->0 and 0->59. No carry between fields.
  - MODE press: pulse SET_LOAD for exactly 1 cycle (the timekeeper's seconds reset to 0), load the shadow with ALM_HOUR/ALM_MIN, cursor to hour, go to SET_ALARM.
- SET_ALARM:
  - NEXT/UP/DOWN behave as in SET_TIME, acting on the shadow.
  - MODE press: copy the shadow into ALM_HOUR/ALM_MIN and return to NORMAL. No SET_LOAD.
- STOP press in either SET state: abandon edits and return to NORMAL, with no load and no alarm update.
- Alarm match: in NORMAL with FLAG[2]=1, on a SEC_TICK cycle where CUR_HOUR==ALM_HOUR, CUR_MIN==ALM_MIN and CUR_SEC==0, go to RINGING and clear the ring counter. No match is checked in the SET states; the alarm is missed, by design.
- RINGING:
  - BUZZ=1 and is registered, asserted the cycle after entry.
  - The ring counter increments on each SEC_TICK.
  - At RING_SEC ticks, or on a STOP or MODE press, BUZZ goes to 0 and the state returns to NORMAL. The alarm stays enabled.
- MERIDIAN is computed combinationally: in NORMAL/RINGING, (CUR_HOUR>=12); in the SET states, (SET_HOUR>=12).
- SET_HOUR/SET_MIN hold their values in NORMAL; the LCD path uses them only in the SET modes.

Decomposition:
- Shared package clock_pkg holds:
  - MODE encodings MODE_NORMAL/MODE_SET_TIME/MODE_SET_ALARM/MODE_RINGING;
  - key index constants KEY_MODE..KEY_STOP;
  - HOUR_MAX=23, MIN_MAX=59;
  - field widths 5/6.
- One sub-module, key_debounce: a single-bit synchroniser, DEB_CYCLES counter and rising-edge pulse, instantiated 6 times.

Test Plan:
- Reset with KEY held at 0 -> MODE=0, FLAG=001, ALM_HOUR=6, ALM_MIN=0, BUZZ=0, SET_LOAD never pulses.
- Bounce: toggle KEY[0] every DEB_CYCLES/2 cycles, then hold it high -> exactly one MODE press, DEB_CYCLES+3 cycles after the last edge, and MODE=1.
- SET_TIME starting from CUR=23:59: UP on hour -> SET_HOUR=0; NEXT then UP -> SET_MIN=0; DOWN -> 59; MODE -> SET_LOAD high for 1 cycle with SET_HOUR=0/SET_MIN=59, and MODE=2.
- SET_ALARM: DOWN on hour from 6 -> 5; MODE -> ALM_HOUR=5, MODE=0. A repeat run that ends with STOP instead leaves ALM_HOUR unchanged.
- Alarm enabled, CUR=05:00:00 with SEC_TICK -> MODE=3 and BUZZ=1 the next cycle. After 60 SEC_TICKs -> BUZZ=0, MODE=0. A repeat run with STOP after 3 ticks -> immediate return to NORMAL.
- UP+DOWN pressed in the same cycle in SET_TIME with hour=12 -> hour becomes 13 (UP wins). Reset asserted mid-RINGING -> BUZZ=0 and MODE=0 the next cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the alarm-clock mode sequencer.
//   - mode_e      : MODE output encoding / controller state
//   - key_act_e   : resolved key action after priority arbitration
//   - KEY_*       : bit positions of the keys within the KEY bus
//   - HOUR_MAX/MIN_MAX and field widths for the time fields
//   - key_resolve : priority encoder STOP > MODE > NEXT > UP > DOWN > ALM_EN
//   - hour_step/min_step : +/-1 on a time field with wrap-around
package clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int NUM_KEYS = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX  = 5'd23;
  localparam logic [HOUR_W-1:0] HOUR_NOON = 5'd12;
  localparam logic [MIN_W-1:0]  MIN_MAX   = 6'd59;

  localparam int KEY_MODE   = 0;
  localparam int KEY_NEXT   = 1;
  localparam int KEY_UP     = 2;
  localparam int KEY_DOWN   = 3;
  localparam int KEY_ALM_EN = 4;
  localparam int KEY_STOP   = 5;

  typedef enum logic [1:0] {
    MODE_NORMAL    = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2,
    MODE_RINGING   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_STOP,
    ACT_MODE,
    ACT_NEXT,
    ACT_UP,
    ACT_DOWN,
    ACT_ALM_EN
  } key_act_e;

  function automatic key_act_e key_resolve(input logic [NUM_KEYS-1:0] press);
    if (press[KEY_STOP])        return ACT_STOP;
    else if (press[KEY_MODE])   return ACT_MODE;
    else if (press[KEY_NEXT])   return ACT_NEXT;
    else if (press[KEY_UP])     return ACT_UP;
    else if (press[KEY_DOWN])   return ACT_DOWN;
    else if (press[KEY_ALM_EN]) return ACT_ALM_EN;
    return ACT_NONE;
  endfunction

  function automatic logic [HOUR_W-1:0] hour_step(input logic [HOUR_W-1:0] h,
                                                  input logic             up);
    if (up) return (h == HOUR_MAX) ? '0 : h + 1'b1;
    return (h == '0) ? HOUR_MAX : h - 1'b1;
  endfunction

  function automatic logic [MIN_W-1:0] min_step(input logic [MIN_W-1:0] m,
                                               input logic            up);
    if (up) return (m == MIN_MAX) ? '0 : m + 1'b1;
    return (m == '0) ? MIN_MAX : m - 1'b1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-FF synchroniser, debounce counter and press pulse.
//   clk_i   : system clock
//   rst_i   : synchronous reset, active-high
//   key_i   : raw asynchronous key level
//   press_o : one-cycle pulse when the accepted level rises
// The accepted level flips after DEB_CYCLES consecutive synchronised samples
// that differ from it; any sample equal to it restarts the count.
module key_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          stable_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        stable_q <= sync_q[1];
        // Pulse only on acceptance of a high level; releases are silent.
        press_q  <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Key-driven mode sequencer for the alarm clock.
//   CLK, RESET        : clock, synchronous active-high reset
//   KEY[5:0]          : MODE, NEXT, UP, DOWN, ALM_EN, STOP (KEY[7:6] unused)
//   SEC_TICK          : one-cycle pulse per second
//   CUR_HOUR/MIN/SEC  : current time from the timekeeper
//   SET_LOAD          : one-cycle load strobe for SET_HOUR/SET_MIN into timekeeper
//   SET_HOUR/SET_MIN  : shadow (edited) time
//   MODE              : NORMAL / SET_TIME / SET_ALARM / RINGING
//   FLAG              : {alarm enabled, minute cursor, hour cursor}
//   MERIDIAN          : PM indicator of the displayed hour
//   ALM_HOUR/ALM_MIN  : stored alarm time
//   BUZZ              : registered buzzer drive
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int DEB_CYCLES = 50000,
  parameter int RING_SEC   = 60
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [7:0]        KEY,
  input  logic              SEC_TICK,
  input  logic [HOUR_W-1:0] CUR_HOUR,
  input  logic [MIN_W-1:0]  CUR_MIN,
  input  logic [SEC_W-1:0]  CUR_SEC,
  output logic              SET_LOAD,
  output logic [HOUR_W-1:0] SET_HOUR,
  output logic [MIN_W-1:0]  SET_MIN,
  output logic [1:0]        MODE,
  output logic [2:0]        FLAG,
  output logic              MERIDIAN,
  output logic [HOUR_W-1:0] ALM_HOUR,
  output logic [MIN_W-1:0]  ALM_MIN,
  output logic              BUZZ
);

  localparam int RW = $clog2(RING_SEC + 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);

  logic [NUM_KEYS-1:0] press;
  logic                unused_keys;
  key_act_e            act;
  logic                alarm_hit;

  mode_e               state_q, state_d;
  logic [HOUR_W-1:0]   hour_q, hour_d;
  logic [MIN_W-1:0]    min_q, min_d;
  logic                cur_min_q, cur_min_d;
  logic                alm_en_q, alm_en_d;
  logic [HOUR_W-1:0]   alm_hour_q, alm_hour_d;
  logic [MIN_W-1:0]    alm_min_q, alm_min_d;
  logic                load_q, load_d;
  logic                buzz_q, buzz_d;
  logic [RW-1:0]       ring_q, ring_d;

  assign unused_keys = ^KEY[7:6];

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .key_i  (KEY[g]),
      .press_o(press[g])
    );
  end

  assign act       = key_resolve(press);
  assign alarm_hit = alm_en_q && SEC_TICK && (CUR_HOUR == alm_hour_q) &&
                     (CUR_MIN == alm_min_q) && (CUR_SEC == '0);

  always_comb begin
    state_d    = state_q;
    hour_d     = hour_q;
    min_d      = min_q;
    cur_min_d  = cur_min_q;
    alm_en_d   = alm_en_q;
    alm_hour_d = alm_hour_q;
    alm_min_d  = alm_min_q;
    load_d     = 1'b0;
    ring_d     = ring_q;

    unique case (state_q)
      MODE_NORMAL: begin
        if (alarm_hit) begin
          state_d = MODE_RINGING;
          ring_d  = '0;
        end else if (act == ACT_MODE) begin
          hour_d    = CUR_HOUR;
          min_d     = CUR_MIN;
          cur_min_d = 1'b0;
          state_d   = MODE_SET_TIME;
        end else if (act == ACT_ALM_EN) begin
          alm_en_d = ~alm_en_q;
        end
      end

      MODE_SET_TIME, MODE_SET_ALARM: begin
        if (act == ACT_STOP) begin
          state_d = MODE_NORMAL;
        end else if (state_q == MODE_SET_ALARM && load_q) begin
          // The shadow still shows the time being loaded during the SET_LOAD
          // cycle, so the alarm values are copied in one cycle later.
          hour_d = alm_hour_q;
          min_d  = alm_min_q;
        end else begin
          unique case (act)
            ACT_MODE: begin
              if (state_q == MODE_SET_TIME) begin
                load_d    = 1'b1;
                cur_min_d = 1'b0;
                state_d   = MODE_SET_ALARM;
              end else begin
                alm_hour_d = hour_q;
                alm_min_d  = min_q;
                state_d    = MODE_NORMAL;
              end
            end
            ACT_NEXT: cur_min_d = ~cur_min_q;
            ACT_UP, ACT_DOWN: begin
              if (cur_min_q) min_d  = min_step(min_q, act == ACT_UP);
              else           hour_d = hour_step(hour_q, act == ACT_UP);
            end
            default: ;
          endcase
        end
      end

      MODE_RINGING: begin
        if (act == ACT_STOP || act == ACT_MODE) begin
          state_d = MODE_NORMAL;
        end else if (SEC_TICK) begin
          if (ring_q == RING_LAST) state_d = MODE_NORMAL;
          else                     ring_d  = ring_q + 1'b1;
        end
      end

      default: state_d = MODE_NORMAL;
    endcase

    buzz_d = (state_d == MODE_RINGING);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= MODE_NORMAL;
      hour_q     <= '0;
      min_q      <= '0;
      cur_min_q  <= 1'b0;
      alm_en_q   <= 1'b0;
      alm_hour_q <= 5'd6;
      alm_min_q  <= '0;
      load_q     <= 1'b0;
      buzz_q     <= 1'b0;
      ring_q     <= '0;
    end else begin
      state_q    <= state_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      cur_min_q  <= cur_min_d;
      alm_en_q   <= alm_en_d;
      alm_hour_q <= alm_hour_d;
      alm_min_q  <= alm_min_d;
      load_q     <= load_d;
      buzz_q     <= buzz_d;
      ring_q     <= ring_d;
    end
  end

  assign MODE     = state_q;
  assign FLAG     = {alm_en_q, cur_min_q, ~cur_min_q};
  assign SET_HOUR = hour_q;
  assign SET_MIN  = min_q;
  assign SET_LOAD = load_q;
  assign ALM_HOUR = alm_hour_q;
  assign ALM_MIN  = alm_min_q;
  assign BUZZ     = buzz_q;
  assign MERIDIAN = (state_q == MODE_SET_TIME || state_q == MODE_SET_ALARM) ?
                    (hour_q >= HOUR_NOON) : (CUR_HOUR >= HOUR_NOON);

endmodule

// File: tb/tb_clock_mode_ctrl.sv
module tb_clock_mode_ctrl;

  localparam int DEB  = 8;
  localparam int RING = 60;
  localparam int K_MODE = 0, K_NEXT = 1, K_UP = 2, K_DOWN = 3, K_ALM = 4, K_STOP = 5;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] KEY;
  logic       SEC_TICK;
  logic [4:0] CUR_HOUR;
  logic [5:0] CUR_MIN;
  logic [5:0] CUR_SEC;
  logic       SET_LOAD;
  logic [4:0] SET_HOUR;
  logic [5:0] SET_MIN;
  logic [1:0] MODE;
  logic [2:0] FLAG;
  logic       MERIDIAN;
  logic [4:0] ALM_HOUR;
  logic [5:0] ALM_MIN;
  logic       BUZZ;

  clock_mode_ctrl #(.DEB_CYCLES(DEB), .RING_SEC(RING)) dut (
    .CLK(CLK), .RESET(RESET), .KEY(KEY), .SEC_TICK(SEC_TICK),
    .CUR_HOUR(CUR_HOUR), .CUR_MIN(CUR_MIN), .CUR_SEC(CUR_SEC),
    .SET_LOAD(SET_LOAD), .SET_HOUR(SET_HOUR), .SET_MIN(SET_MIN),
    .MODE(MODE), .FLAG(FLAG), .MERIDIAN(MERIDIAN),
    .ALM_HOUR(ALM_HOUR), .ALM_MIN(ALM_MIN), .BUZZ(BUZZ)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int load_cnt = 0;

  // Reference model: 0=NORMAL 1=SET_TIME 2=SET_ALARM 3=RINGING
  int m_mode, m_hour, m_min, m_cm, m_alm_en, m_alm_h, m_alm_m, m_loads, m_ring;

  always @(negedge CLK) if (SET_LOAD === 1'b1) load_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_hour = 0; m_min = 0; m_cm = 0;
    m_alm_en = 0; m_alm_h = 6; m_alm_m = 0; m_ring = 0;
  endtask

  task automatic model_key(input int k);
    case (m_mode)
      0: begin
        if (k == K_MODE) begin
          m_hour = int'(CUR_HOUR); m_min = int'(CUR_MIN); m_cm = 0; m_mode = 1;
        end else if (k == K_ALM) m_alm_en = 1 - m_alm_en;
      end
      1, 2: begin
        if (k == K_STOP) m_mode = 0;
        else if (k == K_MODE) begin
          if (m_mode == 1) begin
            m_loads++; m_hour = m_alm_h; m_min = m_alm_m; m_cm = 0; m_mode = 2;
          end else begin
            m_alm_h = m_hour; m_alm_m = m_min; m_mode = 0;
          end
        end else if (k == K_NEXT) m_cm = 1 - m_cm;
        else if (k == K_UP || k == K_DOWN) begin
          if (m_cm == 1) m_min  = (m_min  + ((k == K_UP) ? 1 : 59)) % 60;
          else           m_hour = (m_hour + ((k == K_UP) ? 1 : 23)) % 24;
        end
      end
      default: if (k == K_STOP || k == K_MODE) m_mode = 0;
    endcase
  endtask

  task automatic check_all(input string tag);
    int pm;
    pm = (m_mode == 1 || m_mode == 2) ? (m_hour >= 12) : (int'(CUR_HOUR) >= 12);
    check({tag, ".mode"}, int'(MODE), m_mode);
    check({tag, ".flag"}, int'(FLAG), (m_alm_en * 4) + ((m_cm == 1) ? 2 : 1));
    check({tag, ".alm_h"}, int'(ALM_HOUR), m_alm_h);
    check({tag, ".alm_m"}, int'(ALM_MIN), m_alm_m);
    check({tag, ".buzz"}, int'(BUZZ), (m_mode == 3) ? 1 : 0);
    check({tag, ".merid"}, int'(MERIDIAN), pm);
    check({tag, ".loads"}, load_cnt, m_loads);
    check({tag, ".set_load"}, int'(SET_LOAD), 0);
    if (m_mode == 1 || m_mode == 2) begin
      check({tag, ".set_h"}, int'(SET_HOUR), m_hour);
      check({tag, ".set_m"}, int'(SET_MIN), m_min);
    end
  endtask

  // Holds a key long enough to act, checks latency and any load strobe, then releases.
  task automatic press_key(input string tag, input int k);
    int exp_load, lh, lm, old_mode;
    exp_load = (m_mode == 1 && k == K_MODE) ? 1 : 0;
    lh = m_hour; lm = m_min; old_mode = m_mode;
    KEY[k] = 1'b1;
    tick(DEB + 2);
    check({tag, ".early"}, int'(MODE), old_mode);
    tick(1);
    model_key(k);
    check({tag, ".act_mode"}, int'(MODE), m_mode);
    check({tag, ".load_pulse"}, int'(SET_LOAD), exp_load);
    if (exp_load == 1) begin
      check({tag, ".load_h"}, int'(SET_HOUR), lh);
      check({tag, ".load_m"}, int'(SET_MIN), lm);
    end
    KEY[k] = 1'b0;
    tick(DEB + 3);
    check_all(tag);
  endtask

  task automatic sec_pulse();
    SEC_TICK = 1'b1;
    tick(1);
    SEC_TICK = 1'b0;
    if (m_mode == 3) begin
      m_ring++;
      if (m_ring == RING) m_mode = 0;
    end
  endtask

  task automatic start_ring(input string tag);
    CUR_HOUR = 5'(m_alm_h); CUR_MIN = 6'(m_alm_m); CUR_SEC = '0;
    SEC_TICK = 1'b1;
    tick(1);
    SEC_TICK = 1'b0;
    m_mode = 3; m_ring = 0;
    check({tag, ".ring_mode"}, int'(MODE), 3);
    check({tag, ".ring_buzz"}, int'(BUZZ), 1);
    CUR_SEC = 6'd1;
    tick(1);
  endtask

  initial begin
    RESET = 1'b1; KEY = '0; SEC_TICK = 1'b0;
    CUR_HOUR = 5'd23; CUR_MIN = 6'd59; CUR_SEC = 6'd10;
    m_loads = 0;
    model_reset();

    // Reset values
    tick(3);
    check_all("reset");
    RESET = 1'b0;
    tick(2);
    check_all("post_reset");

    // Bouncing MODE key: only the final stable high level produces one press
    for (int i = 0; i < 6; i++) begin
      KEY[K_MODE] = ~KEY[K_MODE];
      tick(DEB / 2);
      check("bounce.mode", int'(MODE), 0);
    end
    KEY[K_MODE] = 1'b1;
    tick(DEB + 2);
    check("bounce.early", int'(MODE), 0);
    tick(1);
    model_key(K_MODE);
    check("bounce.act", int'(MODE), 1);
    tick(DEB + 6);
    check("bounce.single", int'(MODE), 1);
    KEY[K_MODE] = 1'b0;
    tick(DEB + 3);
    check_all("bounce");

    // SET_TIME wrap from 23:59
    press_key("hour_up_wrap", K_UP);
    check("hour_wrap_val", int'(SET_HOUR), 0);
    press_key("next", K_NEXT);
    press_key("min_up_wrap", K_UP);
    check("min_wrap_val", int'(SET_MIN), 0);
    press_key("min_down_wrap", K_DOWN);
    check("min_down_val", int'(SET_MIN), 59);
    press_key("to_set_alarm", K_MODE);

    // SET_ALARM commit
    press_key("alm_down", K_DOWN);
    check("alm_shadow", int'(SET_HOUR), 5);
    press_key("alm_commit", K_MODE);
    check("alm_hour_5", int'(ALM_HOUR), 5);

    // SET_ALARM abandoned with STOP
    press_key("r_set_time", K_MODE);
    press_key("r_set_alarm", K_MODE);
    press_key("r_down", K_DOWN);
    press_key("r_stop", K_STOP);
    check("alm_kept", int'(ALM_HOUR), 5);

    // Alarm ring to timeout
    press_key("alm_en", K_ALM);
    start_ring("ring1");
    for (int i = 0; i < RING; i++) begin
      sec_pulse();
      check("ring1.mode", int'(MODE), m_mode);
      check("ring1.buzz", int'(BUZZ), (m_mode == 3) ? 1 : 0);
      tick(1);
    end
    check_all("ring1_end");

    // Alarm stopped by STOP after 3 ticks
    start_ring("ring2");
    for (int i = 0; i < 3; i++) begin
      sec_pulse();
      tick(1);
    end
    press_key("ring2_stop", K_STOP);

    // UP and DOWN in the same cycle: UP wins
    CUR_HOUR = 5'd12; CUR_MIN = 6'd30; CUR_SEC = 6'd5;
    press_key("updn_enter", K_MODE);
    KEY[K_UP] = 1'b1; KEY[K_DOWN] = 1'b1;
    tick(DEB + 3);
    model_key(K_UP);
    check("updn.hour", int'(SET_HOUR), 13);
    KEY[K_UP] = 1'b0; KEY[K_DOWN] = 1'b0;
    tick(DEB + 3);
    check_all("updn");
    press_key("updn_stop", K_STOP);

    // Randomised key traffic against the model
    for (int i = 0; i < 60; i++) begin
      int r, k;
      CUR_HOUR = 5'($urandom_range(0, 23));
      CUR_MIN  = 6'($urandom_range(0, 59));
      CUR_SEC  = 6'($urandom_range(0, 59));
      r = int'($urandom_range(0, 19));
      if (r < 3)       k = K_MODE;
      else if (r < 4)  k = K_STOP;
      else if (r < 5)  k = K_ALM;
      else if (r < 10) k = K_NEXT;
      else if (r < 15) k = K_UP;
      else             k = K_DOWN;
      press_key("rand", k);
    end
    if (m_mode != 0) press_key("rand_exit", K_STOP);

    // Reset while ringing
    if (m_alm_en == 0) press_key("en2", K_ALM);
    start_ring("ring3");
    sec_pulse();
    tick(1);
    RESET = 1'b1;
    tick(1);
    check("rst_ring.buzz", int'(BUZZ), 0);
    check("rst_ring.mode", int'(MODE), 0);
    RESET = 1'b0;
    model_reset();
    tick(1);
    check_all("rst_ring");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
